cxapbasyncbridge_master_domain: RTL and testbench

Master-interface end of the APB asynchronous bridge. It receives the 4-phase req/ack handshake and the 65-bit forward payload from the slave-domain half. It replays each transfer as an APB3 master transaction in its own clock domain, then returns read data and the error response on the 33-bit reverse payload with ack. It sits in the peripheral (master-side) clock domain, between the CDC wires and the downstream APB3 bus.

---
 rtl/cxapbasyncbridge_master_domain_pkg.sv | 30 +++
 rtl/cxapbasyncbridge_master_req_sync.sv | 34 +++
 rtl/cxapbasyncbridge_master_domain.sv | 135 +++++++++++++
 tb/tb_cxapbasyncbridge_master_domain.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cxapbasyncbridge_master_domain_pkg.sv
// -----------------------------------------------------------------------------
// cxapbasyncbridge_master_domain_pkg
// Shared definitions for the master-side half of the APB asynchronous bridge:
// CDC payload widths, field positions inside the forward/reverse payloads and
// the replay FSM state encoding.
// -----------------------------------------------------------------------------
package cxapbasyncbridge_master_domain_pkg;

  localparam int FWD_W  = 65;
  localparam int REV_W  = 33;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Forward payload {paddr, pwdata, pwrite}
  localparam int FWD_PWRITE_BIT = 0;
  localparam int FWD_PWDATA_LSB = 1;
  localparam int FWD_PADDR_LSB  = 33;

  // Reverse payload {prdata, pslverr}
  localparam int REV_PSLVERR_BIT = 0;
  localparam int REV_PRDATA_LSB  = 1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_SETUP        = 2'b01,
    ST_ACCESS       = 2'b10,
    ST_WAIT_REQ_LOW = 2'b11
  } state_e;

endpackage

// File: rtl/cxapbasyncbridge_master_req_sync.sv
// -----------------------------------------------------------------------------
// cxapbasyncbridge_master_req_sync
// Multi-flop synchroniser bringing the asynchronous request into the master
// clock domain. Free-running: deliberately not qualified by the APB clock
// enable, so the request keeps propagating while the bus is stalled.
//
// Ports:
//   pclkm      in   master clock
//   presetmn   in   asynchronous active-low reset, clears the chain
//   req_async  in   request from the other clock domain
//   req_sync   out  request after SYNC_STAGES flops
// -----------------------------------------------------------------------------
module cxapbasyncbridge_master_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic pclkm,
  input  logic presetmn,
  input  logic req_async,
  output logic req_sync
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge pclkm or negedge presetmn) begin
    if (!presetmn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_async};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cxapbasyncbridge_master_domain.sv
// -----------------------------------------------------------------------------
// cxapbasyncbridge_master_domain
// Master end of the APB asynchronous bridge. Accepts a 4-phase req/ack
// handshake with a 65-bit forward payload, replays each request as an APB3
// transfer (SETUP then ACCESS, with wait states) and returns
// {prdata, pslverr} on the reverse payload together with ack.
//
// Ports:
//   pclkm, presetmn        clock / asynchronous active-low reset
//   pclkenm                clock enable; FSM and APB/payload registers only
//                          advance on enabled edges
//   apbm_req_async         request in (asynchronous)
//   apbm_ack_async         acknowledge out (registered)
//   apbm_fwd_data_async    {paddr, pwdata, pwrite}, stable while req is high
//   apbm_rev_data_async    {prdata, pslverr}, registered
//   paddrm .. penablem     APB3 master request outputs
//   prdatam, pslverrm,
//   preadym                APB3 completer responses
// -----------------------------------------------------------------------------
module cxapbasyncbridge_master_domain
  import cxapbasyncbridge_master_domain_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclkm,
  input  logic              presetmn,
  input  logic              pclkenm,
  input  logic              apbm_req_async,
  output logic              apbm_ack_async,
  input  logic [FWD_W-1:0]  apbm_fwd_data_async,
  output logic [REV_W-1:0]  apbm_rev_data_async,
  output logic [ADDR_W-1:0] paddrm,
  output logic [DATA_W-1:0] pwdatam,
  output logic              pwritem,
  output logic              pselm,
  output logic              penablem,
  input  logic [DATA_W-1:0] prdatam,
  input  logic              pslverrm,
  input  logic              preadym
);

  state_e state_q;
  state_e state_d;
  logic   req_sync;
  logic   psel_d;
  logic   penable_d;
  logic   ack_d;
  logic   load_fwd;
  logic   load_rev;

  cxapbasyncbridge_master_req_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .pclkm     (pclkm),
    .presetmn  (presetmn),
    .req_async (apbm_req_async),
    .req_sync  (req_sync)
  );

  always_ff @(posedge pclkm or negedge presetmn) begin
    if (!presetmn) begin
      state_q <= ST_IDLE;
    end else if (pclkenm) begin
      state_q <= state_d;
    end
  end

  // A new request is only accepted once ack has returned low, which enforces
  // the full req-up / ack-up / req-down / ack-down cycle between transfers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (req_sync && !apbm_ack_async) state_d = ST_SETUP;
      ST_SETUP:        state_d = ST_ACCESS;
      ST_ACCESS:       if (preadym) state_d = ST_WAIT_REQ_LOW;
      ST_WAIT_REQ_LOW: if (!req_sync) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // Reverse payload is loaded on the same edge ack rises; the other domain
  // only looks at it after synchronising ack, so it is stable by then.
  always_comb begin
    psel_d    = pselm;
    penable_d = penablem;
    ack_d     = apbm_ack_async;
    load_fwd  = 1'b0;
    load_rev  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_SETUP) begin
          load_fwd = 1'b1;
          psel_d   = 1'b1;
        end
      end
      ST_SETUP: penable_d = 1'b1;
      ST_ACCESS: begin
        if (preadym) begin
          load_rev  = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
        end
      end
      ST_WAIT_REQ_LOW: if (!req_sync) ack_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge pclkm or negedge presetmn) begin
    if (!presetmn) begin
      pselm               <= 1'b0;
      penablem            <= 1'b0;
      apbm_ack_async      <= 1'b0;
      paddrm              <= '0;
      pwdatam             <= '0;
      pwritem             <= 1'b0;
      apbm_rev_data_async <= '0;
    end else if (pclkenm) begin
      pselm          <= psel_d;
      penablem       <= penable_d;
      apbm_ack_async <= ack_d;
      if (load_fwd) begin
        paddrm  <= apbm_fwd_data_async[FWD_PADDR_LSB +: ADDR_W];
        pwdatam <= apbm_fwd_data_async[FWD_PWDATA_LSB +: DATA_W];
        pwritem <= apbm_fwd_data_async[FWD_PWRITE_BIT];
      end
      if (load_rev) begin
        apbm_rev_data_async[REV_PRDATA_LSB +: DATA_W] <= prdatam;
        apbm_rev_data_async[REV_PSLVERR_BIT]          <= pslverrm;
      end
    end
  end

endmodule

// File: tb/tb_cxapbasyncbridge_master_domain.sv
`timescale 1ns/1ps
module tb_cxapbasyncbridge_master_domain;

  localparam int SS = 2;
  localparam int SEL_PSEL = 0;
  localparam int SEL_ACK  = 1;

  logic        pclkm = 1'b0;
  logic        presetmn = 1'b0;
  logic        pclkenm = 1'b1;
  logic        req = 1'b0;
  logic [64:0] fwd = '0;
  logic [31:0] prdatam = '0;
  logic        pslverrm = 1'b0;
  logic        preadym = 1'b0;

  logic        ack;
  logic [32:0] rev;
  logic [31:0] paddrm;
  logic [31:0] pwdatam;
  logic        pwritem;
  logic        pselm;
  logic        penablem;

  int n_cmp = 0;
  int n_bad = 0;
  bit toggle_en = 1'b0;

  cxapbasyncbridge_master_domain #(.SYNC_STAGES(SS)) dut (
    .pclkm               (pclkm),
    .presetmn            (presetmn),
    .pclkenm             (pclkenm),
    .apbm_req_async      (req),
    .apbm_ack_async      (ack),
    .apbm_fwd_data_async (fwd),
    .apbm_rev_data_async (rev),
    .paddrm              (paddrm),
    .pwdatam             (pwdatam),
    .pwritem             (pwritem),
    .pselm               (pselm),
    .penablem            (penablem),
    .prdatam             (prdatam),
    .pslverrm            (pslverrm),
    .preadym             (preadym)
  );

  always #5 pclkm = ~pclkm;

  // Behavioural model: the request is seen SS clocks late; the bus phase is
  // inferred from which of psel/penable/ack are currently asserted.
  logic [SS-1:0] m_hist = '0;
  logic          m_psel = 1'b0;
  logic          m_pen = 1'b0;
  logic          m_ack = 1'b0;
  logic          m_pwrite = 1'b0;
  logic [31:0]   m_paddr = '0;
  logic [31:0]   m_pwdata = '0;
  logic [32:0]   m_rev = '0;

  always @(posedge pclkm or negedge presetmn) begin
    if (!presetmn) begin
      m_hist <= '0; m_psel <= 1'b0; m_pen <= 1'b0; m_ack <= 1'b0;
      m_pwrite <= 1'b0; m_paddr <= '0; m_pwdata <= '0; m_rev <= '0;
    end else begin
      m_hist <= {m_hist[SS-2:0], req};
      if (pclkenm) begin
        if (!m_psel && !m_ack && m_hist[SS-1]) begin
          m_psel   <= 1'b1;
          m_paddr  <= fwd[64:33];
          m_pwdata <= fwd[32:1];
          m_pwrite <= fwd[0];
        end else if (m_psel && !m_pen) begin
          m_pen <= 1'b1;
        end else if (m_pen && preadym) begin
          m_psel <= 1'b0;
          m_pen  <= 1'b0;
          m_ack  <= 1'b1;
          m_rev  <= {prdatam, pslverrm};
        end else if (m_ack && !m_hist[SS-1]) begin
          m_ack <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge pclkm) begin
    chk("ack", 64'(ack), 64'(m_ack));
    chk("psel", 64'(pselm), 64'(m_psel));
    chk("penable", 64'(penablem), 64'(m_pen));
    chk("pwrite", 64'(pwritem), 64'(m_pwrite));
    chk("paddr", 64'(paddrm), 64'(m_paddr));
    chk("pwdata", 64'(pwdatam), 64'(m_pwdata));
    chk("rev", 64'(rev), 64'(m_rev));
    chk("psel_ack_overlap", 64'(pselm & ack), 64'd0);
  end

  task automatic tick();
    @(negedge pclkm);
    if (toggle_en) pclkenm = ~pclkenm;
  endtask

  function automatic logic sig(input int sel);
    return (sel == SEL_PSEL) ? pselm : ack;
  endfunction

  task automatic wait_sig(input int sel, input logic val, input string name, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (sig(sel) !== val && cyc < 64);
    if (sig(sel) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got %b expected %b", name, sig(sel), val);
    end
  endtask

  initial begin
    int cnt;
    int pen_cnt;
    int s;
    bit seen;

    // Reset
    repeat (3) tick();
    chk("reset_ctrl", 64'({ack, pselm, penablem, pwritem}), 64'd0);
    chk("reset_paddr", 64'(paddrm), 64'd0);
    chk("reset_rev", 64'(rev), 64'd0);
    presetmn = 1'b1;
    repeat (2) tick();

    // Write, zero wait states
    fwd = {32'h4000_0010, 32'hDEAD_BEEF, 1'b1};
    prdatam = 32'hCAFE_0001; pslverrm = 1'b0; preadym = 1'b1;
    req = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "wr_psel", cnt);
    chk("wr_psel_lat", 64'(cnt), 64'd3);
    chk("wr_paddr", 64'(paddrm), 64'h4000_0010);
    chk("wr_pwdata", 64'(pwdatam), 64'hDEAD_BEEF);
    chk("wr_pwrite", 64'(pwritem), 64'd1);
    chk("wr_pen_setup", 64'(penablem), 64'd0);
    tick();
    chk("wr_penable", 64'(penablem), 64'd1);
    tick();
    chk("wr_ack", 64'(ack), 64'd1);
    chk("wr_rev", 64'(rev), 64'({32'hCAFE_0001, 1'b0}));
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "wr_ack_fall", cnt);
    chk("wr_ack_fall_lat", 64'(cnt), 64'd3);
    repeat (2) tick();

    // Read with five wait states and an error response
    fwd = {32'h4000_0020, 32'h0000_0000, 1'b0};
    preadym = 1'b0; prdatam = 32'hFFFF_0000; pslverrm = 1'b0;
    req = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "rd_psel", cnt);
    pen_cnt = 0;
    repeat (6) begin
      tick();
      if (penablem) pen_cnt++;
    end
    prdatam = 32'h1234_5678; pslverrm = 1'b1; preadym = 1'b1;
    tick();
    chk("rd_pen_cycles", 64'(pen_cnt), 64'd6);
    chk("rd_ack", 64'(ack), 64'd1);
    chk("rd_psel_low", 64'(pselm | penablem), 64'd0);
    chk("rd_rev", 64'(rev), 64'({32'h1234_5678, 1'b1}));
    preadym = 1'b0; prdatam = 32'h0; pslverrm = 1'b0;
    repeat (4) begin
      tick();
      chk("rd_rev_hold", 64'(rev), 64'({32'h1234_5678, 1'b1}));
    end
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "rd_ack_fall", cnt);
    chk("rd_ack_fall_lat", 64'(cnt), 64'd3);
    chk("rd_rev_kept", 64'(rev), 64'({32'h1234_5678, 1'b1}));
    repeat (2) tick();

    // Write with pclkenm toggling every cycle
    fwd = {32'h4000_0030, 32'h0BAD_F00D, 1'b1};
    prdatam = 32'h5555_AAAA; pslverrm = 1'b0; preadym = 1'b1;
    toggle_en = 1'b1;
    req = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "en_psel", cnt);
    s = 1;
    while (!penablem && s < 10) begin
      tick();
      if (pselm && !penablem) s++;
    end
    chk("en_setup_len", 64'(s), 64'd2);
    wait_sig(SEL_ACK, 1'b1, "en_ack", cnt);
    chk("en_rev", 64'(rev), 64'({32'h5555_AAAA, 1'b0}));
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "en_ack_fall", cnt);
    toggle_en = 1'b0;
    pclkenm = 1'b1;
    repeat (2) tick();

    // Back-to-back transfers
    fwd = {32'h4000_0040, 32'h1111_2222, 1'b1};
    prdatam = 32'hAAAA_0001;
    req = 1'b1;
    wait_sig(SEL_ACK, 1'b1, "b2b_ack1", cnt);
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "b2b_ack1_fall", cnt);
    fwd = {32'h4000_0050, 32'h0, 1'b0};
    prdatam = 32'hBBBB_0002;
    req = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "b2b_psel2", cnt);
    chk("b2b_psel2_lat", 64'(cnt), 64'd3);
    chk("b2b_paddr2", 64'(paddrm), 64'h4000_0050);
    wait_sig(SEL_ACK, 1'b1, "b2b_ack2", cnt);
    chk("b2b_rev2", 64'(rev), 64'({32'hBBBB_0002, 1'b0}));
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "b2b_ack2_fall", cnt);
    repeat (2) tick();

    // Reset asserted during ACCESS, request still held afterwards
    fwd = {32'h4000_0060, 32'h0, 1'b0};
    preadym = 1'b0;
    req = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "rst_psel", cnt);
    tick();
    #2 presetmn = 1'b0;
    #1;
    chk("rst_async_psel", 64'(pselm), 64'd0);
    chk("rst_async_pen", 64'(penablem), 64'd0);
    chk("rst_async_ack", 64'(ack), 64'd0);
    tick();
    fwd = {32'h4000_0070, 32'h7777_8888, 1'b1};
    tick();
    presetmn = 1'b1;
    wait_sig(SEL_PSEL, 1'b1, "rst_psel2", cnt);
    chk("rst_psel2_lat", 64'(cnt), 64'd3);
    chk("rst_paddr2", 64'(paddrm), 64'h4000_0070);
    chk("rst_pwdata2", 64'(pwdatam), 64'h7777_8888);
    prdatam = 32'hCCCC_0003; preadym = 1'b1;
    wait_sig(SEL_ACK, 1'b1, "rst_ack2", cnt);
    req = 1'b0;
    wait_sig(SEL_ACK, 1'b0, "rst_ack2_fall", cnt);
    repeat (2) tick();

    // Request glitch that never straddles a clock edge
    @(negedge pclkm);
    #1 req = 1'b1;
    #2 req = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | pselm | ack;
    end
    chk("glitch_filtered", 64'(seen), 64'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
